switch_round_ctrl: RTL and testbench
====================================

SWITCH_ROUND_CTRL -- requirements
Module: switch_round_ctrl

Interface
REQ-001 SHALL have parameter N_SW, default 10, number of switches/LEDs (2..16).
REQ-002 SHALL have parameter TICK_DIV, default 50000000, clk cycles per one-second tick.
REQ-003 SHALL have parameter ROUND_SEC, default 15, seconds allowed per round (1..63).
REQ-004 SHALL have parameter GAP_SEC, default 5, seconds between rounds (1..63).
REQ-005 SHALL have parameter STREAK, default 5, passes per point-doubling step.
REQ-006 SHALL have parameter SCORE_W, default 12, score width.
REQ-007 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-008 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-009 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-010 SHALL have port start  in  1  one-cycle pulse, begins new game.
REQ-011 SHALL have port sw  in  N_SW  switch levels, already synchronised/debounced.
REQ-012 SHALL have port led  out  N_SW  prompt LEDs.
REQ-013 SHALL have port secs_left  out  6  current countdown value.
REQ-014 SHALL have port score  out  SCORE_W  accumulated points.
REQ-015 SHALL have port round_num  out  8  rounds passed this game.
REQ-016 SHALL have port state_o  out  2  IDLE=0, PLAY=1, GAP=2, OVER=3.
REQ-017 SHALL have ports pass_pulse, fail_pulse  out  1 each  one-cycle event strobes.

Function
REQ-018 SHALL implement FSM IDLE, PLAY, GAP, OVER; state_o equals encoded state; all outputs registered.
REQ-019 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every cycle in all states.
REQ-020 SHALL, on start in IDLE or OVER, clear score and round_num and enter PLAY next edge; start in PLAY/GAP ignored.
REQ-021 SHALL, on every PLAY entry, capture idx = lfsr mod N_SW, snap = sw, expected = sw XOR onehot(idx), led = onehot(idx), secs_left = ROUND_SEC, tick counter = 0.
REQ-022 SHALL count tick counter 0..TICK_DIV-1 in PLAY/GAP, asserting internal tick when at TICK_DIV-1 and wrapping to 0; counter held at 0 in IDLE/OVER.
REQ-023 SHALL decrement secs_left by 1 on each tick in PLAY/GAP, never below 0.
REQ-024 SHALL, in PLAY, evaluate sampled sw at every edge after entry: sw==expected -> pass; sw!=snap and sw!=expected -> fail (wrong or extra switch); else wait.
REQ-025 SHALL treat tick with secs_left==1 in PLAY and no pass as timeout -> fail; secs_left becomes 0.
REQ-026 SHALL give pass priority over timeout when both occur at the same edge.
REQ-027 SHALL, on pass: award pts = 2 << min(round_num/STREAK, 3) using pre-increment round_num; score saturates at all-ones; round_num saturates at 255; led = 0; secs_left = GAP_SEC; tick counter = 0; enter GAP; pass_pulse high exactly one cycle.
REQ-028 SHALL, on fail: enter OVER, led = all ones, score/round_num frozen, secs_left = 0, fail_pulse high exactly one cycle.
REQ-029 SHALL, in GAP, ignore sw; on tick with secs_left==1 enter PLAY (new prompt per REQ-021, snap taken at that edge).
REQ-030 SHALL hold all outputs stable in OVER until start.
REQ-031 SHALL guarantee pass_pulse and fail_pulse never high in the same cycle.

Reset
REQ-032 SHALL, at any rising clk edge with reset_n low, regardless of state: state IDLE, led 0, secs_left 0, score 0, round_num 0, pulses 0, tick counter 0, LFSR = LFSR_SEED.
REQ-033 SHALL abort a round in progress on reset mid-PLAY/GAP with no pass/fail pulse emitted.

Verification (TICK_DIV=4, ROUND_SEC=3, GAP_SEC=2, N_SW=10)
REQ-034 SHALL verify reset then start: state_o=1 next cycle, exactly one led bit set, secs_left=3.
REQ-035 SHALL verify flipping the lit switch: pass_pulse one cycle, score=2, round_num=1, state_o=2, secs_left=2, led=0; PLAY re-entered after 8 cycles.
REQ-036 SHALL verify flipping an unlit switch in PLAY: fail_pulse one cycle, state_o=3, led=10'h3FF, score unchanged.
REQ-037 SHALL verify no switch activity: fail at 12th cycle after PLAY entry with secs_left=0; correct flip on that same edge yields pass instead.
REQ-038 SHALL verify 5 consecutive passes then a 6th: score 10 then 14; score saturation with SCORE_W=4 stays 15.
REQ-039 SHALL verify reset_n low mid-GAP: all outputs return to REQ-032 values next edge, no pulses.

Source files
------------

// File: rtl/switch_round_ctrl.sv
// Switch-flip reaction game: each round lights one LED and the player must toggle
// exactly that switch before the per-round countdown expires.
module switch_round_ctrl #(
  parameter int          N_SW      = 10,
  parameter int          TICK_DIV  = 50000000,
  parameter int          ROUND_SEC = 15,
  parameter int          GAP_SEC   = 5,
  parameter int          STREAK    = 5,
  parameter int          SCORE_W   = 12,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [N_SW-1:0]    sw,
  output logic [N_SW-1:0]    led,
  output logic [5:0]         secs_left,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         round_num,
  output logic [1:0]         state_o,
  output logic               pass_pulse,
  output logic               fail_pulse
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam int SUM_W = SCORE_W + 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_SW-1:0]    snap_q, snap_d;
  logic [N_SW-1:0]    target_q, target_d;
  logic [N_SW-1:0]    led_d;
  logic [5:0]         secs_d;
  logic [SCORE_W-1:0] score_d;
  logic [7:0]         round_d;
  logic               pass_d, fail_d;

  logic               tick;
  logic               enter_play;
  logic [15:0]        idx;
  logic [N_SW-1:0]    prompt;
  logic [7:0]         level;
  logic [1:0]         shift;
  logic [SUM_W-1:0]   sum;
  logic [SCORE_W-1:0] score_sat;

  assign state_o = state_q;

  always_comb begin
    tick   = (cnt_q == CNT_LAST);
    idx    = lfsr_q % 16'(N_SW);
    prompt = N_SW'(1) << idx;
    // Points double every STREAK passes, capped after three doublings.
    level  = round_num / 8'(STREAK);
    shift  = (level > 8'd3) ? 2'd3 : level[1:0];
    sum    = SUM_W'(score) + (SUM_W'(2) << shift);
    score_sat = (sum[SUM_W-1:SCORE_W] != '0) ? '1 : sum[SCORE_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    target_d   = target_q;
    led_d      = led;
    secs_d     = secs_left;
    score_d    = score;
    round_d    = round_num;
    pass_d     = 1'b0;
    fail_d     = 1'b0;
    enter_play = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        cnt_d = '0;
        if (start) begin
          score_d    = '0;
          round_d    = '0;
          enter_play = 1'b1;
        end
      end
      S_PLAY: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick && secs_left != 6'd0) secs_d = secs_left - 6'd1;
        // A correct answer on the final tick still counts as a pass.
        if (sw == target_q) begin
          state_d = S_GAP;
          score_d = score_sat;
          round_d = (round_num == 8'hFF) ? 8'hFF : round_num + 8'd1;
          led_d   = '0;
          secs_d  = 6'(GAP_SEC);
          cnt_d   = '0;
          pass_d  = 1'b1;
        end else if (sw != snap_q || (tick && secs_left == 6'd1)) begin
          state_d = S_OVER;
          led_d   = '1;
          secs_d  = 6'd0;
          cnt_d   = '0;
          fail_d  = 1'b1;
        end
      end
      S_GAP: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick && secs_left != 6'd0) secs_d = secs_left - 6'd1;
        if (tick && secs_left == 6'd1) enter_play = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_play) begin
      state_d  = S_PLAY;
      snap_d   = sw;
      target_d = sw ^ prompt;
      led_d    = prompt;
      secs_d   = 6'(ROUND_SEC);
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      cnt_q      <= '0;
      snap_q     <= '0;
      target_q   <= '0;
      led        <= '0;
      secs_left  <= '0;
      score      <= '0;
      round_num  <= '0;
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      target_q   <= target_d;
      led        <= led_d;
      secs_left  <= secs_d;
      score      <= score_d;
      round_num  <= round_d;
      pass_pulse <= pass_d;
      fail_pulse <= fail_d;
    end
  end

endmodule

// File: tb/tb_switch_round_ctrl.sv
// Bench for switch_round_ctrl: randomized games, a reference model of the scoring
// and prompt rules, and a pulse-driven scoreboard.
module tb_switch_round_ctrl;
  localparam int N  = 10;
  localparam int TD = 4;
  localparam int RS = 3;
  localparam int GS = 2;
  localparam int ST = 5;
  localparam int SW_W = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int W = 31;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [N-1:0] sw = '0;
  logic [N-1:0] led;
  logic [5:0] secs_left;
  logic [SW_W-1:0] score;
  logic [7:0] round_num;
  logic [1:0] state_o;
  logic pass_pulse, fail_pulse;

  always #5 clk = ~clk;

  switch_round_ctrl #(
    .N_SW(N), .TICK_DIV(TD), .ROUND_SEC(RS), .GAP_SEC(GS),
    .STREAK(ST), .SCORE_W(SW_W), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sw(sw), .led(led),
    .secs_left(secs_left), .score(score), .round_num(round_num),
    .state_o(state_o), .pass_pulse(pass_pulse), .fail_pulse(fail_pulse)
  );

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_got, mon_want;

  // Reference model state
  logic [15:0] m_lfsr;
  int m_score, m_round, m_idx;
  logic [N-1:0] m_snap, m_target;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk) m_lfsr <= reset_n ? lfsr_next(m_lfsr) : SEED;

  // Scoreboard monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (reset_n && (pass_pulse || fail_pulse)) begin
      mon_got = {pass_pulse, score, round_num, state_o, led, secs_left};
      total++;
      if (pass_pulse && fail_pulse) begin
        bad++;
        $display("FAIL both_pulses got pass=%b fail=%b want one only", pass_pulse, fail_pulse);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse got=%h want=none", mon_got);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          bad++;
          $display("FAIL pulse_event got=%h want=%h", mon_got, mon_want);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      cyc();
      k++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL no_response got=none want=%h", exp_q[0]);
      exp_q.delete();
    end
  endtask

  task automatic enter_check(input logic [N-1:0] s);
    m_snap = s;
    m_target = s ^ (10'd1 << m_idx);
    chk("play_state", 32'(state_o), 32'd1);
    chk("play_led", 32'(led), 32'(10'd1 << m_idx));
    chk("play_secs", 32'(secs_left), 32'(RS));
    chk("play_score", 32'(score), 32'(m_score));
    chk("play_round", 32'(round_num), 32'(m_round));
  endtask

  task automatic start_game();
    logic [N-1:0] s;
    start = 1'b1;
    m_idx = int'(m_lfsr) % N;
    s = sw;
    cyc();
    start = 1'b0;
    m_score = 0;
    m_round = 0;
    enter_check(s);
  endtask

  task automatic do_pass(input int d);
    int pts, lvl;
    repeat (d) cyc();
    lvl = m_round / ST;
    pts = 2 << ((lvl > 3) ? 3 : lvl);
    m_score = (m_score + pts > 15) ? 15 : m_score + pts;
    m_round = (m_round < 255) ? m_round + 1 : 255;
    exp_q.push_back({1'b1, 4'(m_score), 8'(m_round), 2'd2, 10'd0, 6'(GS)});
    sw = m_target;
    cyc();
    chk("gap_state", 32'(state_o), 32'd2);
    drain();
  endtask

  task automatic gap_to_play(input bit poke);
    logic [N-1:0] s;
    for (int i = 1; i <= 6; i++) begin
      if (i == 1 && poke) start = 1'b1;
      cyc();
      start = 1'b0;
      if (i == 1 && poke) begin
        chk("start_in_gap_state", 32'(state_o), 32'd2);
        chk("start_in_gap_round", 32'(round_num), 32'(m_round));
      end
      sw = 10'($urandom_range(0, 1023));
    end
    cyc();
    chk("gap_len", 32'(state_o), 32'd2);
    m_idx = int'(m_lfsr) % N;
    s = sw;
    cyc();
    enter_check(s);
  endtask

  task automatic hold_over();
    repeat (3) begin
      sw = 10'($urandom_range(0, 1023));
      cyc();
    end
    chk("over_state", 32'(state_o), 32'd3);
    chk("over_led", 32'(led), 32'h3FF);
    chk("over_score", 32'(score), 32'(m_score));
    chk("over_round", 32'(round_num), 32'(m_round));
    chk("over_secs", 32'(secs_left), 32'd0);
  endtask

  task automatic do_wrong(input int d, input bit extra);
    int j;
    repeat (d) cyc();
    j = $urandom_range(0, N - 2);
    if (j >= m_idx) j++;
    exp_q.push_back({1'b0, 4'(m_score), 8'(m_round), 2'd3, 10'h3FF, 6'd0});
    sw = (extra ? m_target : m_snap) ^ (10'd1 << j);
    cyc();
    chk("wrong_state", 32'(state_o), 32'd3);
    drain();
    hold_over();
  endtask

  task automatic do_timeout();
    repeat (11) cyc();
    chk("pre_timeout_state", 32'(state_o), 32'd1);
    chk("pre_timeout_secs", 32'(secs_left), 32'd1);
    exp_q.push_back({1'b0, 4'(m_score), 8'(m_round), 2'd3, 10'h3FF, 6'd0});
    cyc();
    chk("timeout_state", 32'(state_o), 32'd3);
    chk("timeout_secs", 32'(secs_left), 32'd0);
    drain();
    hold_over();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_led"}, 32'(led), 32'd0);
    chk({tag, "_secs"}, 32'(secs_left), 32'd0);
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_round"}, 32'(round_num), 32'd0);
    chk({tag, "_pulses"}, 32'({pass_pulse, fail_pulse}), 32'd0);
  endtask

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int nr, act;
    sw = 10'($urandom_range(0, 1023));
    cyc();
    cyc();
    check_reset_values("reset");
    reset_n = 1'b1;
    cyc();
    chk("idle_hold", 32'(state_o), 32'd0);

    // Long game: streak doubling and 4-bit score saturation; one pass on the timeout edge.
    start_game();
    for (int r = 0; r < 8; r++) begin
      do_pass((r == 3) ? 11 : $urandom_range(0, 10));
      gap_to_play(r == 1);
    end
    chk("saturated_score", 32'(score), 32'd15);
    do_wrong($urandom_range(0, 10), 1'b0);

    start_game();
    do_pass($urandom_range(0, 10));
    gap_to_play(1'b0);
    do_timeout();

    start_game();
    do_wrong($urandom_range(0, 10), 1'b1);

    repeat (3) begin
      start_game();
      nr = $urandom_range(0, 4);
      for (int i = 0; i < nr; i++) begin
        do_pass($urandom_range(0, 11));
        gap_to_play(1'b0);
      end
      act = $urandom_range(0, 2);
      if (act == 0) do_wrong($urandom_range(0, 10), 1'b0);
      else if (act == 1) do_wrong($urandom_range(0, 10), 1'b1);
      else do_timeout();
    end

    // Reset in the middle of a gap aborts silently.
    start_game();
    do_pass($urandom_range(0, 10));
    repeat (3) cyc();
    reset_n = 1'b0;
    cyc();
    check_reset_values("gap_reset");
    reset_n = 1'b1;
    cyc();
    check_reset_values("post_reset");
    start_game();
    do_pass($urandom_range(0, 10));
    gap_to_play(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
